// File: rtl/cpu_pkg.sv
// Shared pipeline-control encodings: hazard FSM states and operand forwarding selects.
// The decoder, D_Ex consumer and Ex operand mux all use these same codes.
package cpu_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10,
        HALT  = 2'b11
    } hz_state_t;

    typedef enum logic [1:0] {
        FWD_NONE = 2'b00,
        FWD_EX   = 2'b01,
        FWD_MEM  = 2'b10
    } fwd_t;

endpackage : cpu_pkg

// File: rtl/hazard_ctrl_fwd_sel.sv
// Operand forwarding comparator for one Decode source operand.
// Purely combinational; the Ex-stage match has priority over the Mem-stage match.
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [1:0] src,
    input  logic       use_src,
    input  logic [1:0] ex_rd,
    input  logic       ex_RW,
    input  logic       ex_is_load,
    input  logic [1:0] mem_rd,
    input  logic       mem_RW,
    output logic [1:0] fwd
);

    // A load in Ex has no result yet, so it can never be an Ex forward source.
    logic ex_hit;
    logic mem_hit;

    assign ex_hit  = use_src && ex_RW && !ex_is_load && (ex_rd == src);
    assign mem_hit = use_src && mem_RW && (mem_rd == src);

    always_comb begin
        if (ex_hit) begin
            fwd = FWD_EX;
        end else if (mem_hit) begin
            fwd = FWD_MEM;
        end else begin
            fwd = FWD_NONE;
        end
    end

endmodule : fwd_sel

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: load-use stalls, taken-branch flushes, halt, and
// per-operand forwarding selects for the F_D / D_Ex latches and PC.
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int LOAD_STALL = 1,
    parameter int BR_PENALTY = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] id_ra,
    input  logic [1:0] id_rb,
    input  logic       id_use_ra,
    input  logic       id_use_rb,
    input  logic [1:0] ex_rd,
    input  logic       ex_RW,
    input  logic       ex_is_load,
    input  logic [1:0] mem_rd,
    input  logic       mem_RW,
    input  logic       ex_br_taken,
    input  logic       ex_Hlt,
    output logic       pc_ld,
    output logic       fd_ld,
    output logic       fd_flush,
    output logic       dex_ld,
    output logic       dex_flush,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       halted,
    output logic [1:0] state
);

    // Counter preloads: the cycle that detects the hazard is the first of the window.
    localparam int          STALL_INIT_I = (LOAD_STALL > 1) ? LOAD_STALL - 2 : 0;
    localparam int          FLUSH_INIT_I = (BR_PENALTY > 1) ? BR_PENALTY - 2 : 0;
    localparam logic [1:0]  STALL_INIT   = STALL_INIT_I[1:0];
    localparam logic [1:0]  FLUSH_INIT   = FLUSH_INIT_I[1:0];

    hz_state_t  state_q, state_d;
    logic [1:0] cnt_q, cnt_d;
    logic       halted_q, halted_d;
    logic       load_use;

    fwd_sel u_fwd_a (
        .src        (id_ra),
        .use_src    (id_use_ra),
        .ex_rd      (ex_rd),
        .ex_RW      (ex_RW),
        .ex_is_load (ex_is_load),
        .mem_rd     (mem_rd),
        .mem_RW     (mem_RW),
        .fwd        (fwd_a)
    );

    fwd_sel u_fwd_b (
        .src        (id_rb),
        .use_src    (id_use_rb),
        .ex_rd      (ex_rd),
        .ex_RW      (ex_RW),
        .ex_is_load (ex_is_load),
        .mem_rd     (mem_rd),
        .mem_RW     (mem_RW),
        .fwd        (fwd_b)
    );

    assign load_use = ex_RW && ex_is_load &&
                      ((id_use_ra && (ex_rd == id_ra)) || (id_use_rb && (ex_rd == id_rb)));

    always_comb begin
        // NOTE: every output and next-state value gets a default first so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        halted_d  = halted_q;
        pc_ld     = 1'b1;
        fd_ld     = 1'b1;
        dex_ld    = 1'b1;
        fd_flush  = 1'b0;
        dex_flush = 1'b0;

        unique case (state_q)
            RUN: begin
                if (ex_Hlt) begin
                    pc_ld     = 1'b0;
                    fd_ld     = 1'b0;
                    dex_ld    = 1'b0;
                    dex_flush = 1'b1;
                    state_d   = HALT;
                    halted_d  = 1'b1;
                end else if (ex_br_taken) begin
                    fd_flush  = 1'b1;
                    dex_flush = 1'b1;
                    if (BR_PENALTY > 1) begin
                        state_d = FLUSH;
                        cnt_d   = FLUSH_INIT;
                    end
                end else if (load_use) begin
                    pc_ld     = 1'b0;
                    fd_ld     = 1'b0;
                    dex_flush = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_d = STALL;
                        cnt_d   = STALL_INIT;
                    end
                end
            end
            STALL: begin
                pc_ld     = 1'b0;
                fd_ld     = 1'b0;
                dex_flush = 1'b1;
                if (cnt_q == 2'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 2'd1;
            end
            FLUSH: begin
                fd_flush  = 1'b1;
                dex_flush = 1'b1;
                if (cnt_q == 2'd0) state_d = RUN;
                else               cnt_d   = cnt_q - 2'd1;
            end
            HALT: begin
                pc_ld  = 1'b0;
                fd_ld  = 1'b0;
                dex_ld = 1'b0;
            end
            default: state_d = RUN;
        endcase

        // While reset is held the pipeline latches free-run with no flushes.
        if (!reset) begin
            pc_ld     = 1'b1;
            fd_ld     = 1'b1;
            dex_ld    = 1'b1;
            fd_flush  = 1'b0;
            dex_flush = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= RUN;
            cnt_q    <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    assign halted = halted_q;
    assign state  = state_q;

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: vector table for forwarding/load-use in RUN,
// plus hand-written sequences for multi-cycle stall, flush, halt and async reset.
module tb_hazard_ctrl;

    logic       clk;
    logic       reset;
    logic [1:0] id_ra, id_rb, ex_rd, mem_rd;
    logic       id_use_ra, id_use_rb, ex_RW, ex_is_load, mem_RW, ex_br_taken, ex_Hlt;

    logic       pc_ld, fd_ld, fd_flush, dex_ld, dex_flush, halted;
    logic [1:0] fwd_a, fwd_b, state;
    logic       pc_ld3, fd_ld3, fd_flush3, dex_ld3, dex_flush3, halted3;
    logic [1:0] fwd_a3, fwd_b3, state3;

    int tests;
    int fails;

    hazard_ctrl u_dut (
        .clk(clk), .reset(reset),
        .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
        .ex_rd(ex_rd), .ex_RW(ex_RW), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_RW(mem_RW), .ex_br_taken(ex_br_taken), .ex_Hlt(ex_Hlt),
        .pc_ld(pc_ld), .fd_ld(fd_ld), .fd_flush(fd_flush), .dex_ld(dex_ld),
        .dex_flush(dex_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .state(state)
    );

    hazard_ctrl #(.LOAD_STALL(3), .BR_PENALTY(2)) u_dut3 (
        .clk(clk), .reset(reset),
        .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
        .ex_rd(ex_rd), .ex_RW(ex_RW), .ex_is_load(ex_is_load),
        .mem_rd(mem_rd), .mem_RW(mem_RW), .ex_br_taken(ex_br_taken), .ex_Hlt(ex_Hlt),
        .pc_ld(pc_ld3), .fd_ld(fd_ld3), .fd_flush(fd_flush3), .dex_ld(dex_ld3),
        .dex_flush(dex_flush3), .fwd_a(fwd_a3), .fwd_b(fwd_b3), .halted(halted3), .state(state3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ra;
        logic [1:0] rb;
        logic       use_ra;
        logic       use_rb;
        logic [1:0] xrd;
        logic       xrw;
        logic       xld;
        logic [1:0] mrd;
        logic       mrw;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        logic       e_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic check1(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        id_ra = 2'd0; id_rb = 2'd0; id_use_ra = 1'b0; id_use_rb = 1'b0;
        ex_rd = 2'd0; ex_RW = 1'b0; ex_is_load = 1'b0;
        mem_rd = 2'd0; mem_RW = 1'b0; ex_br_taken = 1'b0; ex_Hlt = 1'b0;
    endtask

    // Load-use hazard on operand B: load to r1 in Ex, Decode reads r1 via rb.
    task automatic load_use_inputs();
        idle_inputs();
        ex_rd = 2'd1; ex_RW = 1'b1; ex_is_load = 1'b1;
        id_rb = 2'd1; id_use_rb = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic check_run_idle(input string tag);
        check1({tag, " pc_ld"}, pc_ld, 1'b1);
        check1({tag, " fd_ld"}, fd_ld, 1'b1);
        check1({tag, " dex_ld"}, dex_ld, 1'b1);
        check1({tag, " fd_flush"}, fd_flush, 1'b0);
        check1({tag, " dex_flush"}, dex_flush, 1'b0);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        //          ra    rb   ura   urb   xrd  xrw   xld   mrd  mrw    e_fa   e_fb  stall
        vecs[0] = '{2'd2, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0, 2'd2, 1'b1, 2'b01, 2'b00, 1'b0};
        vecs[1] = '{2'd2, 2'd0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 2'd2, 1'b1, 2'b10, 2'b00, 1'b0};
        vecs[2] = '{2'd2, 2'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'd2, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[3] = '{2'd2, 2'd0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 2'd2, 1'b1, 2'b10, 2'b00, 1'b1};
        vecs[4] = '{2'd0, 2'd3, 1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 2'd3, 1'b1, 2'b00, 2'b01, 1'b0};
        vecs[5] = '{2'd0, 2'd1, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd1, 1'b1, 2'b00, 2'b10, 1'b0};
        vecs[6] = '{2'd0, 2'd0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0, 2'd3, 1'b1, 2'b01, 2'b01, 1'b0};
        vecs[7] = '{2'd2, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd2, 1'b1, 2'b10, 2'b00, 1'b1};
        vecs[8] = '{2'd1, 2'd1, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 2'd1, 1'b1, 2'b00, 2'b00, 1'b0};
        vecs[9] = '{2'd3, 2'd2, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0, 2'd3, 1'b0, 2'b00, 2'b00, 1'b0};

        // Reset state, with a hazard present on the inputs: ld stays forced high.
        reset = 1'b0;
        idle_inputs();
        #2;
        check2("rst state", state, 2'b00);
        check1("rst halted", halted, 1'b0);
        check2("rst fwd_a", fwd_a, 2'b00);
        check2("rst fwd_b", fwd_b, 2'b00);
        check_run_idle("rst");
        load_use_inputs();
        #1;
        check1("rst hazard pc_ld", pc_ld, 1'b1);
        check1("rst hazard fd_ld", fd_ld, 1'b1);
        check1("rst hazard dex_flush", dex_flush, 1'b0);
        @(negedge clk);
        idle_inputs();
        #1 reset = 1'b1;

        // Table: forwarding and single-cycle load-use in RUN (default LOAD_STALL=1).
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            id_ra = vecs[i].ra; id_rb = vecs[i].rb;
            id_use_ra = vecs[i].use_ra; id_use_rb = vecs[i].use_rb;
            ex_rd = vecs[i].xrd; ex_RW = vecs[i].xrw; ex_is_load = vecs[i].xld;
            mem_rd = vecs[i].mrd; mem_RW = vecs[i].mrw;
            #1;
            check2($sformatf("vec%0d fwd_a", i), fwd_a, vecs[i].e_fa);
            check2($sformatf("vec%0d fwd_b", i), fwd_b, vecs[i].e_fb);
            check1($sformatf("vec%0d pc_ld", i), pc_ld, !vecs[i].e_stall);
            check1($sformatf("vec%0d fd_ld", i), fd_ld, !vecs[i].e_stall);
            check1($sformatf("vec%0d dex_ld", i), dex_ld, 1'b1);
            check1($sformatf("vec%0d dex_flush", i), dex_flush, vecs[i].e_stall);
            check1($sformatf("vec%0d fd_flush", i), fd_flush, 1'b0);
            check2($sformatf("vec%0d state", i), state, 2'b00);
        end

        // Load-use: one-cycle bubble on the default instance, three on LOAD_STALL=3.
        do_reset();
        @(negedge clk);
        load_use_inputs();
        #1;
        check1("lu1 c1 pc_ld", pc_ld, 1'b0);
        check1("lu1 c1 fd_ld", fd_ld, 1'b0);
        check1("lu1 c1 dex_flush", dex_flush, 1'b1);
        check1("lu3 c1 pc_ld", pc_ld3, 1'b0);
        check2("lu3 c1 state", state3, 2'b00);
        @(negedge clk);
        idle_inputs();
        #1;
        check2("lu1 c2 state", state, 2'b00);
        check_run_idle("lu1 c2");
        check2("lu3 c2 state", state3, 2'b01);
        check1("lu3 c2 pc_ld", pc_ld3, 1'b0);
        check1("lu3 c2 dex_flush", dex_flush3, 1'b1);
        @(negedge clk);
        #1;
        check2("lu3 c3 state", state3, 2'b01);
        check1("lu3 c3 pc_ld", pc_ld3, 1'b0);
        check1("lu3 c3 fd_ld", fd_ld3, 1'b0);
        @(negedge clk);
        #1;
        check2("lu3 c4 state", state3, 2'b00);
        check1("lu3 c4 pc_ld", pc_ld3, 1'b1);
        check1("lu3 c4 dex_flush", dex_flush3, 1'b0);

        // Taken branch with a coincident load-use: flush wins, load-use ignored in FLUSH.
        @(negedge clk);
        load_use_inputs();
        ex_br_taken = 1'b1;
        #1;
        check1("br c1 pc_ld", pc_ld, 1'b1);
        check1("br c1 fd_ld", fd_ld, 1'b1);
        check1("br c1 fd_flush", fd_flush, 1'b1);
        check1("br c1 dex_flush", dex_flush, 1'b1);
        check2("br c1 state", state, 2'b00);
        @(negedge clk);
        ex_br_taken = 1'b0;
        #1;
        check2("br c2 state", state, 2'b10);
        check1("br c2 pc_ld", pc_ld, 1'b1);
        check1("br c2 fd_flush", fd_flush, 1'b1);
        check1("br c2 dex_flush", dex_flush, 1'b1);
        check2("br c2 state3", state3, 2'b10);
        @(negedge clk);
        idle_inputs();
        #1;
        check2("br c3 state", state, 2'b00);
        check2("br c3 state3", state3, 2'b00);
        check_run_idle("br c3");

        // Halt together with a taken branch: halt wins and holds against any inputs.
        @(negedge clk);
        ex_Hlt = 1'b1;
        ex_br_taken = 1'b1;
        #1;
        check1("hlt c1 pc_ld", pc_ld, 1'b0);
        check1("hlt c1 fd_ld", fd_ld, 1'b0);
        check1("hlt c1 dex_ld", dex_ld, 1'b0);
        check1("hlt c1 dex_flush", dex_flush, 1'b1);
        check1("hlt c1 fd_flush", fd_flush, 1'b0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            {id_ra, id_rb, ex_rd, mem_rd} = 8'($urandom);
            {id_use_ra, id_use_rb, ex_RW, ex_is_load, mem_RW, ex_br_taken, ex_Hlt} = 7'($urandom);
            #1;
            check2($sformatf("hlt %0d state", i), state, 2'b11);
            check1($sformatf("hlt %0d halted", i), halted, 1'b1);
            check1($sformatf("hlt %0d pc_ld", i), pc_ld, 1'b0);
            check1($sformatf("hlt %0d fd_ld", i), fd_ld, 1'b0);
            check1($sformatf("hlt %0d dex_ld", i), dex_ld, 1'b0);
            check1($sformatf("hlt %0d fd_flush", i), fd_flush, 1'b0);
            check1($sformatf("hlt %0d dex_flush", i), dex_flush, 1'b0);
        end
        #1 reset = 1'b0;
        idle_inputs();
        #1;
        check2("hlt rst state", state, 2'b00);
        check1("hlt rst halted", halted, 1'b0);
        check1("hlt rst pc_ld", pc_ld, 1'b1);
        @(negedge clk);
        #1 reset = 1'b1;

        // Async reset between edges while in FLUSH.
        @(negedge clk);
        ex_br_taken = 1'b1;
        @(negedge clk);
        ex_br_taken = 1'b0;
        #1;
        check2("afl pre state", state, 2'b10);
        #1 reset = 1'b0;
        #1;
        check2("afl rst state", state, 2'b00);
        check2("afl rst state3", state3, 2'b00);
        check1("afl rst halted", halted, 1'b0);
        check1("afl rst fd_flush", fd_flush, 1'b0);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        #1;
        check2("afl post state", state, 2'b00);
        check_run_idle("afl post");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_hazard_ctrl
